// File: rtl/tx_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-stream TX path among N_REQ sources.
// Grant is held until the granted source's last beat or a forced last at MAX_BEATS.
//
// state  | meaning
// IDLE   | no grant; pick the next valid requester from ptr, one-cycle arbitration
// STREAM | granted requester muxed straight through to the TX datapath
// GAP    | inter-packet idle, GAP_CYCLES long, nothing granted
module tx_stream_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 1500,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [N_REQ-1:0]            i_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [N_REQ-1:0]            i_last,
  output logic [N_REQ-1:0]            o_ready,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_last,
  input  logic                        i_ready,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_busy,
  output logic                        o_trunc
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int GAP_W = 8;

  localparam logic [CNT_W-1:0] FORCE_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W:0]   N_WIDE    = (IDX_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [N_REQ-1:0]   grant_q,    grant_d;
  logic [IDX_W-1:0]   gidx_q,     gidx_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;

  logic               any_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W:0]     cand;

  logic               in_stream;
  logic               g_valid;
  logic               g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic               force_last;
  logic               xfer;
  logic               pkt_end;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel_idx   = ptr_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= N_WIDE) begin
        cand = cand - N_WIDE;
      end
      if (i_valid[cand[IDX_W-1:0]]) begin
        sel_idx   = cand[IDX_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign in_stream  = (state_q == ST_STREAM);
  assign g_valid    = i_valid[gidx_q];
  assign g_last     = i_last[gidx_q];
  assign g_data     = i_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign force_last = (beat_cnt_q == FORCE_CNT);
  assign xfer       = in_stream & g_valid & i_ready;
  assign pkt_end    = g_last | force_last;

  assign o_valid = in_stream & g_valid;
  assign o_data  = in_stream ? g_data : '0;
  assign o_last  = in_stream & pkt_end;
  assign o_ready = in_stream ? (grant_q & {N_REQ{i_ready}}) : '0;
  assign o_grant = in_stream ? grant_q : '0;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_trunc = xfer & force_last & ~g_last;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d          = ST_STREAM;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          ptr_d            = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
          beat_cnt_d       = '0;
        end
      end

      ST_STREAM: begin
        // A dropped valid mid-packet simply stalls here; the grant is kept.
        if (xfer) begin
          if (pkt_end) begin
            beat_cnt_d = '0;
            grant_d    = '0;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: per-requester source queues drive the DUTs,
// expected beats are queued at stimulus time and a negedge monitor checks every transfer.
module tb_tx_stream_arbiter;

  logic       clk;
  logic       rst     [2];
  logic [3:0] t_valid [2];
  logic [31:0] t_data [2];
  logic [3:0] t_last  [2];
  logic       t_ready [2];
  logic [3:0] d_ready [2];
  logic       d_valid [2];
  logic [7:0] d_data  [2];
  logic       d_last  [2];
  logic [3:0] d_grant [2];
  logic       d_busy  [2];
  logic       d_trunc [2];

  // dut 0: short MAX_BEATS for truncation, no gap; dut 1: default MAX_BEATS, 3-cycle gap
  tx_stream_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BEATS(4), .GAP_CYCLES(0)) u_dut_a (
    .i_clock(clk), .i_reset(rst[0]), .i_valid(t_valid[0]), .i_data(t_data[0]),
    .i_last(t_last[0]), .o_ready(d_ready[0]), .o_valid(d_valid[0]), .o_data(d_data[0]),
    .o_last(d_last[0]), .i_ready(t_ready[0]), .o_grant(d_grant[0]), .o_busy(d_busy[0]),
    .o_trunc(d_trunc[0])
  );

  tx_stream_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BEATS(1500), .GAP_CYCLES(3)) u_dut_b (
    .i_clock(clk), .i_reset(rst[1]), .i_valid(t_valid[1]), .i_data(t_data[1]),
    .i_last(t_last[1]), .o_ready(d_ready[1]), .o_valid(d_valid[1]), .o_data(d_data[1]),
    .o_last(d_last[1]), .i_ready(t_ready[1]), .o_grant(d_grant[1]), .o_busy(d_busy[1]),
    .o_trunc(d_trunc[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] mem [2][4][64];
  int head [2][4] = '{default: 0};
  int tail [2][4] = '{default: 0};
  int skip [2][4] = '{default: 0};
  logic [3:0] fire [2];

  // expected beat: {trunc, last, grant[3:0], data[7:0]}
  logic [13:0] exp0[$];
  logic [13:0] exp1[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%0h expected=%0h", nm, d, got, want);
    end
  endtask

  task automatic src_push(input int d, input int r, input logic [7:0] data, input logic last);
    mem[d][r][tail[d][r]] = {last, data};
    tail[d][r]++;
  endtask

  task automatic exp_push(input int d, input int r, input logic [7:0] data, input logic last,
                          input logic trunc);
    logic [13:0] e;
    e = {trunc, last, 4'(1 << r), data};
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  task automatic pkt(input int d, input int r, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_push(d, r, base + 8'(i), i == n - 1);
      exp_push(d, r, base + 8'(i), i == n - 1, 1'b0);
    end
  endtask

  task automatic clear_src(input int d, input int r);
    skip[d][r] = tail[d][r];
  endtask

  function automatic bit src_empty(input int d);
    for (int r = 0; r < 4; r++) begin
      if (head[d][r] < tail[d][r] && head[d][r] >= skip[d][r]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int exp_size(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic pulse_reset(input int d);
    @(posedge clk); #2;
    rst[d] = 1'b1;
    @(posedge clk); #2;
    rst[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = !d_busy[d] && src_empty(d) && exp_size(d) == 0;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle dut%0d timeout: busy=%0b pending_expected=%0d required idle with 0 pending",
               d, d_busy[d], exp_size(d));
    end
  endtask

  // Source model: pops a beat when the DUT accepted it in the previous cycle.
  initial begin
    for (int d = 0; d < 2; d++) begin
      t_valid[d] = '0;
      t_data[d]  = '0;
      t_last[d]  = '0;
      fire[d]    = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) fire[d] = d_ready[d] & t_valid[d];
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 4; r++) begin
          if (fire[d][r] && head[d][r] < tail[d][r]) head[d][r]++;
          if (head[d][r] < skip[d][r]) head[d][r] = skip[d][r];
          if (head[d][r] < tail[d][r]) begin
            t_valid[d][r]       = 1'b1;
            t_data[d][r*8 +: 8] = mem[d][r][head[d][r]][7:0];
            t_last[d][r]        = mem[d][r][head[d][r]][8];
          end else begin
            t_valid[d][r]       = 1'b0;
            t_data[d][r*8 +: 8] = 8'h00;
            t_last[d][r]        = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [13:0] got;
    logic [13:0] want;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("ready_map", d, {28'b0, d_ready[d]}, {28'b0, d_grant[d] & {4{t_ready[d]}}});
        if (d_valid[d] && t_ready[d]) begin
          got = {d_trunc[d], d_last[d], d_grant[d], d_data[d]};
          if (exp_size(d) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d got=%0h expected=none", d, got);
          end else begin
            if (d == 0) want = exp0.pop_front();
            else        want = exp1.pop_front();
            chk("beat", d, {18'b0, got}, {18'b0, want});
          end
        end else begin
          chk("trunc_idle", d, {31'b0, d_trunc[d]}, 32'd0);
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    bit seen;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    t_ready[0] = 1'b1;
    t_ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_state", d, {12'b0, d_valid[d], d_last[d], d_busy[d], d_trunc[d],
                             d_ready[d], d_grant[d], d_data[d]}, 32'd0);
    end

    // single requester, one arbitration cycle then three back-to-back beats
    @(posedge clk); #2;
    pkt(0, 1, 8'hA1, 3);
    @(posedge clk);
    @(negedge clk);
    chk("t1_arb_latency", 0, {29'b0, d_valid[0], d_busy[0], |d_grant[0]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_grant", 0, {28'b0, d_grant[0]}, 32'h2);
      chk("t1_valid", 0, {31'b0, d_valid[0]}, 32'd1);
    end
    @(negedge clk);
    chk("t1_back_idle", 0, {26'b0, d_busy[0], d_valid[0], d_grant[0]}, 32'd0);
    wait_idle(0, 20);

    // all four requesters with two 2-beat packets each: order 0,1,2,3,0,1,2,3
    pulse_reset(0);
    @(posedge clk); #2;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 2; p++) begin
        src_push(0, r, 8'((r << 4) | (p * 2)),     1'b0);
        src_push(0, r, 8'((r << 4) | (p * 2 + 1)), 1'b1);
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 4; r++) begin
        exp_push(0, r, 8'((r << 4) | (p * 2)),     1'b0, 1'b0);
        exp_push(0, r, 8'((r << 4) | (p * 2 + 1)), 1'b1, 1'b0);
      end
    end
    wait_idle(0, 200);

    // backpressure on r2: i_ready 1,0,1,0,... data holds while stalled
    @(posedge clk); #2;
    pkt(0, 2, 8'hC0, 4);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #2;
      t_ready[0] = (k % 2 == 0);
      @(negedge clk);
      chk("bp_ready", 0, {31'b0, d_ready[0][2]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("bp_data", 0, {24'b0, d_data[0]}, 32'hC0 + 32'((k + 1) / 2));
      chk("bp_valid", 0, {31'b0, d_valid[0]}, 32'd1);
    end
    @(posedge clk); #2;
    t_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_done", 0, {31'b0, d_busy[0]}, 32'd0);
    wait_idle(0, 20);

    // truncation at MAX_BEATS=4, then remainder re-arbitrated; grant held across valid drop
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) src_push(0, 0, 8'hD0 + 8'(i), 1'b0);
    exp_push(0, 0, 8'hD0, 1'b0, 1'b0);
    exp_push(0, 0, 8'hD1, 1'b0, 1'b0);
    exp_push(0, 0, 8'hD2, 1'b0, 1'b0);
    exp_push(0, 0, 8'hD3, 1'b1, 1'b1);
    exp_push(0, 0, 8'hD4, 1'b0, 1'b0);
    exp_push(0, 0, 8'hD5, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = src_empty(0);
    end
    chk("t4_drained", 0, {31'b0, seen}, 32'd1);
    chk("t4_hold_busy", 0, {27'b0, d_busy[0], d_grant[0]}, 32'h11);
    chk("t4_hold_novalid", 0, {31'b0, d_valid[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_hold_grant", 0, {28'b0, d_grant[0]}, 32'h1);
    @(posedge clk); #2;
    src_push(0, 0, 8'hD6, 1'b1);
    exp_push(0, 0, 8'hD6, 1'b1, 1'b0);
    wait_idle(0, 20);

    // reset during beat 2 of r1's packet; afterwards ptr=0 so r0 wins over r1 and r3
    @(posedge clk); #2;
    src_push(0, 1, 8'hE0, 1'b0);
    src_push(0, 1, 8'hE1, 1'b0);
    src_push(0, 1, 8'hE2, 1'b1);
    exp_push(0, 1, 8'hE0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst[0]     = 1'b1;
    t_ready[0] = 1'b0;
    clear_src(0, 1);
    @(posedge clk); #2;
    rst[0]     = 1'b0;
    t_ready[0] = 1'b1;
    @(negedge clk);
    chk("t5_post_reset", 0, {12'b0, d_valid[0], d_last[0], d_busy[0], d_trunc[0],
                             d_ready[0], d_grant[0], d_data[0]}, 32'd0);
    @(posedge clk); #2;
    pkt(0, 0, 8'h50, 2);
    pkt(0, 1, 8'h60, 2);
    pkt(0, 3, 8'h70, 2);
    wait_idle(0, 60);

    // three-cycle gap after r0's last, then IDLE, then r3
    @(posedge clk); #2;
    pkt(1, 0, 8'hF0, 2);
    pkt(1, 3, 8'hF8, 2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = d_valid[1] && d_last[1] && t_ready[1];
    end
    chk("t6_last_seen", 1, {31'b0, seen}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_busy[1] && !d_valid[1]) cnt++;
      else break;
    end
    chk("t6_gap_len", 1, 32'(cnt), 32'd3);
    chk("t6_idle", 1, {26'b0, d_busy[1], d_valid[1], d_grant[1]}, 32'd0);
    @(negedge clk);
    chk("t6_r3_grant", 1, {28'b0, d_grant[1]}, 32'h8);
    wait_idle(1, 40);

    // single-beat packet
    @(posedge clk); #2;
    pkt(1, 2, 8'h33, 1);
    wait_idle(1, 40);

    chk("sb_drain", 0, 32'(exp0.size()), 32'd0);
    chk("sb_drain", 1, 32'(exp1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
